// File: rtl/data_mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - RV32 load/store funct3 codes
//   - FSM state encoding
//   - width-class codes (funct3[1:0]) and the zero-extend bit position
//   - store lane helpers and the misalignment predicate
package data_mem_access_unit_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // funct3[1:0] width class; every other code is treated as a word access
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;

  // funct3 bit that selects zero-extension on loads
  localparam int F3_UNSIGNED_BIT = 2;

  function automatic logic [3:0] store_be(input logic [1:0] width, input logic [1:0] off);
    logic [3:0] be;
    case (width)
      W_BYTE:  be = 4'b0001 << off;
      W_HALF:  be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] width, input logic [31:0] wd);
    logic [31:0] data;
    case (width)
      W_BYTE:  data = {4{wd[7:0]}};
      W_HALF:  data = {2{wd[15:0]}};
      default: data = wd;
    endcase
    return data;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
    logic mis;
    case (width)
      W_BYTE:  mis = 1'b0;
      W_HALF:  mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_access_unit_load_data_aligner.sv
// Load data aligner (combinational).
// Picks the addressed byte/half lane out of the memory read word and sign- or
// zero-extends it to 32 bits. Word-class codes pass the read word through.
// Ports:
//   i_rdata   32  read word from data memory
//   i_offset   2  latched byte offset (address bits [1:0])
//   i_funct3   3  latched load funct3
//   o_data    32  extended load result
module data_mem_access_unit_load_data_aligner
  import data_mem_access_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unsigned;

  assign w_unsigned = i_funct3[F3_UNSIGNED_BIT];
  // half lane only looks at offset[1]; offset[0] is ignored for halves
  assign w_half     = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_offset)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  always_comb begin
    o_data = i_rdata;
    case (i_funct3[1:0])
      W_BYTE:  o_data = w_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      W_HALF:  o_data = w_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store unit.
// Converts ALU address, store data and funct3 into a word-aligned, byte-enabled
// data-memory transaction over a req/ack handshake, and returns extended load data
// registered on READ_DATA. BUSY_WAIT stalls the pipeline while an access is pending.
// Optional build macro: DATA_MEM_MISALIGN_TRAP_EN -- misaligned half/word accesses
// skip memory, go straight to DONE and pulse MISALIGNED. Undefined: MISALIGNED is 0.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   MEM_READ, MEM_WRITE   load / store request (store wins)
//   FUNCT3, ADDRESS       width code and byte address
//   WRITE_DATA            store data
//   READ_DATA             extended load result (held until next load ack)
//   BUSY_WAIT             pipeline stall
//   BUS_ERROR, MISALIGNED one-cycle status pulses (visible in DONE)
//   DMEM_*                data memory request/response
// FSM:
//   state  | meaning
//   IDLE   | waiting for an op; latches the transaction
//   ACCESS | request outstanding, waiting for ack or watchdog
//   DONE   | single cycle where the pipeline advances
module data_mem_access_unit
  import data_mem_access_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY_WAIT,
  output logic        BUS_ERROR,
  output logic        MISALIGNED,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK
);

  localparam bit WD_EN = (ACK_TIMEOUT != 0);
  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int TC    = WD_EN ? ACK_TIMEOUT - 1 : 0;

  state_e      r_state, w_next_state;
  logic        r_req, r_we, r_bus_error, r_misaligned;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_read_data;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic [CNT_W-1:0] r_cnt;

  logic        w_op, w_misaligned, w_timeout_hit;
  logic        w_start, w_trap, w_ack_done, w_timeout;
  logic [31:0] w_load_data;

  assign w_op = MEM_READ | MEM_WRITE;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign w_misaligned = is_misaligned(FUNCT3[1:0], ADDRESS[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_timeout_hit = WD_EN && (r_cnt == CNT_W'(TC));

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_trap       = 1'b0;
    w_ack_done   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_op) begin
          if (w_misaligned) begin
            w_trap       = 1'b1;
            w_next_state = ST_DONE;
          end else begin
            w_start      = 1'b1;
            w_next_state = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // ack has priority over a watchdog expiring in the same cycle
        if (DMEM_ACK) begin
          w_ack_done   = 1'b1;
          w_next_state = ST_DONE;
        end else if (w_timeout_hit) begin
          w_timeout    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  data_mem_access_unit_load_data_aligner u_aligner (
    .i_rdata  (DMEM_RDATA),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_be         <= 4'h0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_funct3     <= 3'h0;
      r_offset     <= 2'h0;
      r_cnt        <= '0;
      r_read_data  <= 32'h0;
      r_bus_error  <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      // status flags are single-cycle pulses
      r_bus_error  <= 1'b0;
      r_misaligned <= 1'b0;
      if (w_start) begin
        r_req    <= 1'b1;
        r_we     <= MEM_WRITE;
        r_addr   <= {ADDRESS[31:2], 2'b00};
        r_be     <= MEM_WRITE ? store_be(FUNCT3[1:0], ADDRESS[1:0]) : 4'hF;
        r_wdata  <= store_wdata(FUNCT3[1:0], WRITE_DATA);
        r_funct3 <= FUNCT3;
        r_offset <= ADDRESS[1:0];
      end
      if (w_trap) r_misaligned <= 1'b1;
      if (r_state == ST_ACCESS) begin
        if (w_ack_done) begin
          r_req <= 1'b0;
          r_cnt <= '0;
          if (!r_we) r_read_data <= w_load_data;
        end else if (w_timeout) begin
          r_req       <= 1'b0;
          r_cnt       <= '0;
          r_bus_error <= 1'b1;
        end else if (WD_EN) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign BUSY_WAIT  = w_op && (r_state != ST_DONE);
  assign READ_DATA  = r_read_data;
  assign BUS_ERROR  = r_bus_error;
  assign MISALIGNED = r_misaligned;
  assign DMEM_REQ   = r_req;
  assign DMEM_WE    = r_we;
  assign DMEM_ADDR  = r_addr;
  assign DMEM_BE    = r_be;
  assign DMEM_WDATA = r_wdata;

endmodule
